// File: rtl/traffic_pkg.sv
// Segment patterns and digit-select encoding for the countdown display.
// Seg bit0 = a .. bit6 = g; Dig_En bit3 = A_H .. bit0 = B_L.
package traffic_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Slot number equals the Dig_En bit it drives.
    typedef enum logic [1:0] {
        SLOT_B_L = 2'd0,
        SLOT_B_H = 2'd1,
        SLOT_A_L = 2'd2,
        SLOT_A_H = 2'd3
    } slot_t;

    function automatic logic [3:0] slot_dig_en(input slot_t s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/traffic_display_scan_bcd_to_seg.sv
// BCD digit to 7-segment decoder with blank override; purely combinational.
// 0-9 standard glyphs, 10-14 off, 15 dash.
module bcd_to_seg
    import traffic_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_val)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                4'd15:   o_seg = SEG_DASH;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/traffic_display_scan.sv
// Multiplexed 4-digit countdown display and lamp driver with wink blinking.
// Lamps and Seg lag inputs by one Clk; digits are sampled once per frame; no backpressure.
module traffic_display_scan
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       A_Light,
    input  logic       B_Light,
    input  logic [3:0] A_Time_H,
    input  logic [3:0] A_Time_L,
    input  logic [3:0] B_Time_H,
    input  logic [3:0] B_Time_L,
    input  logic       Wink,
    output logic [6:0] Seg,
    output logic [3:0] Dig_En,
    output logic       Led_A_Grn,
    output logic       Led_A_Red,
    output logic       Led_B_Grn,
    output logic       Led_B_Red
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_presc;
    slot_t         r_slot;
    logic [3:0]    r_sh_a_h, r_sh_a_l, r_sh_b_h, r_sh_b_l;
    logic [FW-1:0] r_frame_cnt;
    logic          r_phase;
    logic [6:0]    r_seg;
    logic          r_a_grn, r_a_red, r_b_grn, r_b_red;

    logic          w_slot_end, w_frame_start, w_dark, w_blank;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_nxt;

    assign w_slot_end    = (r_presc == PRESC_LAST);
    assign w_frame_start = w_slot_end && (r_slot == SLOT_B_L);
    assign w_dark        = Wink && !r_phase;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_presc <= '0;
            r_slot  <= SLOT_A_H;
        end else if (w_slot_end) begin
            r_presc <= '0;
            r_slot  <= slot_t'(r_slot - 2'd1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Shadow digits change only as the scan re-enters A_H, so one frame is always coherent.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sh_a_h <= 4'hF;
            r_sh_a_l <= 4'hF;
            r_sh_b_h <= 4'hF;
            r_sh_b_l <= 4'hF;
        end else if (w_frame_start) begin
            r_sh_a_h <= A_Time_H;
            r_sh_a_l <= A_Time_L;
            r_sh_b_h <= B_Time_H;
            r_sh_b_l <= B_Time_L;
        end
    end

    // Phase only matters while winking; parking it on with a cleared count outside
    // wink makes both Wink edges start (or recover) lit without extra edge logic.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!Wink) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_frame_start) begin
            if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
        end
    end

    always_comb begin
        w_digit = r_sh_b_l;
        w_blank = 1'b0;
        case (r_slot)
            SLOT_A_H: begin w_digit = r_sh_a_h; w_blank = (r_sh_a_h == 4'd0); end
            SLOT_A_L: w_digit = r_sh_a_l;
            SLOT_B_H: begin w_digit = r_sh_b_h; w_blank = (r_sh_b_h == 4'd0); end
            default:  w_digit = r_sh_b_l;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .i_val   (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg_nxt)
    );

    // Seg settles one Clk into a slot, inside the blanking window (BLANK_CYC >= 1).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_seg   <= '0;
            r_a_grn <= 1'b0;
            r_a_red <= 1'b0;
            r_b_grn <= 1'b0;
            r_b_red <= 1'b0;
        end else begin
            r_seg   <= w_seg_nxt;
            r_a_grn <= A_Light;
            r_a_red <= ~A_Light;
            r_b_grn <= B_Light;
            r_b_red <= ~B_Light;
        end
    end

    assign Seg       = r_seg;
    assign Dig_En    = ((r_presc >= BLANK_END) && !w_dark) ? slot_dig_en(r_slot) : 4'b0000;
    assign Led_A_Grn = r_a_grn & ~w_dark;
    assign Led_A_Red = r_a_red & ~w_dark;
    assign Led_B_Grn = r_b_grn & ~w_dark;
    assign Led_B_Red = r_b_red & ~w_dark;

endmodule

// File: tb/tb_traffic_display_scan.sv
// Randomized bench for traffic_display_scan against a frame-arithmetic reference model.
module tb_traffic_display_scan;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       A_Light, B_Light, Wink;
    logic [3:0] A_Time_H, A_Time_L, B_Time_H, B_Time_L;
    logic [6:0] Seg;
    logic [3:0] Dig_En;
    logic       Led_A_Grn, Led_A_Red, Led_B_Grn, Led_B_Red;

    traffic_display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .A_Light   (A_Light),
        .B_Light   (B_Light),
        .A_Time_H  (A_Time_H),
        .A_Time_L  (A_Time_L),
        .B_Time_H  (B_Time_H),
        .B_Time_L  (B_Time_L),
        .Wink      (Wink),
        .Seg       (Seg),
        .Dig_En    (Dig_En),
        .Led_A_Grn (Led_A_Grn),
        .Led_A_Red (Led_A_Red),
        .Led_B_Grn (Led_B_Grn),
        .Led_B_Red (Led_B_Red)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: edges since reset release, digits captured at each frame start,
    // frames seen since Wink went high, and the lamp inputs seen at the last edge.
    int unsigned m_n;
    logic [3:0]  m_sh [4];
    int unsigned m_frames;
    logic        m_a, m_b;
    bit          m_run;

    function automatic logic [6:0] ref_seg(input logic [3:0] v, input bit tens);
        if (tens && v == 4'd0) return 7'h00;
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  4'd15: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    function automatic bit model_dark();
        return Wink && (((m_frames / BF) % 2) == 1);
    endfunction

    task automatic model_reset();
        m_n = 0; m_frames = 0; m_run = 0; m_a = 0; m_b = 0;
        for (int i = 0; i < 4; i++) m_sh[i] = 4'hF;
    endtask

    task automatic model_step();
        m_n++;
        if (m_n % FRAME == 0) begin
            m_sh[3] = A_Time_H; m_sh[2] = A_Time_L;
            m_sh[1] = B_Time_H; m_sh[0] = B_Time_L;
            if (Wink) m_frames++;
        end
        if (!Wink) m_frames = 0;
        m_a = A_Light; m_b = B_Light; m_run = 1;
    endtask

    task automatic check_outputs();
        int         slot;
        bit         dark;
        logic [3:0] exp_en;
        logic [3:0] exp_led;
        slot   = 3 - int'((m_n / SD) % 4);
        dark   = model_dark();
        exp_en = (!dark && (m_n % SD) >= BC) ? (4'b0001 << slot) : 4'b0000;
        chk("dig_en", Dig_En, exp_en);
        if (exp_en != 4'b0000) chk("seg", Seg, ref_seg(m_sh[slot], (slot % 2) == 1));
        if (!Rst_n) chk("seg_rst", Seg, 7'h00);
        exp_led = (m_run && !dark) ? {m_a, ~m_a, m_b, ~m_b} : 4'b0000;
        chk("leds", {Led_A_Grn, Led_A_Red, Led_B_Grn, Led_B_Red}, exp_led);
    endtask

    task automatic step();
        @(posedge Clk);
        if (Rst_n) model_step();
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic set_digits(input logic [3:0] ah, al, bh, bl);
        A_Time_H = ah; A_Time_L = al; B_Time_H = bh; B_Time_L = bl;
    endtask

    task automatic random_poke();
        case ($urandom_range(0, 11))
            0: A_Time_H = 4'($urandom_range(0, 15));
            1: A_Time_L = 4'($urandom_range(0, 15));
            2: B_Time_H = 4'($urandom_range(0, 15));
            3: B_Time_L = 4'($urandom_range(0, 15));
            4: A_Light  = ~A_Light;
            5: B_Light  = ~B_Light;
            default: ;
        endcase
    endtask

    logic [3:0] seq [$];
    int         active [4];
    logic [3:0] prev_en;

    initial begin
        Rst_n = 1'b0; A_Light = 1'b1; B_Light = 1'b0; Wink = 1'b0;
        set_digits(4'd3, 4'd7, 4'd1, 4'd2);
        model_reset();
        repeat (3) step();
        Rst_n = 1'b1;
        #1 check_outputs();

        // First frame shows dashes, second shows 3 7 1 2 in scan order.
        repeat (FRAME) step();
        prev_en = 4'b0000;
        for (int i = 0; i < 4; i++) active[i] = 0;
        repeat (FRAME) begin
            step();
            if (Dig_En != 4'b0000 && prev_en == 4'b0000) seq.push_back(Dig_En);
            for (int i = 0; i < 4; i++) if (Dig_En == (4'b0001 << i)) active[i]++;
            prev_en = Dig_En;
        end
        chk("scan_len", seq.size(), 4);
        for (int i = 0; i < 4 && i < seq.size(); i++) chk("scan_order", seq[i], 4'b1000 >> i);
        for (int i = 0; i < 4; i++) chk("active_cycles", active[i], SD - BC);

        // A_L changes during the A_L slot; the change must wait for the next frame.
        while ((m_n % FRAME) != SD + 3) step();
        A_Time_L = 4'd6;
        repeat (2 * FRAME) step();

        set_digits(4'd0, 4'd5, 4'd0, 4'd0);
        repeat (2 * FRAME) step();
        set_digits(4'hF, 4'hF, 4'hF, 4'hF);
        repeat (2 * FRAME) step();
        set_digits(4'd10, 4'd12, 4'd14, 4'd9);
        repeat (FRAME) step();

        repeat (6 * FRAME) begin
            random_poke();
            step();
        end

        // Wink: blink with random traffic, then drop Wink inside an off phase.
        Wink = 1'b1;
        repeat (9 * FRAME) begin
            random_poke();
            step();
        end
        for (int i = 0; i < 8 * FRAME && !model_dark(); i++) step();
        chk("dark_dig_en", Dig_En, 4'b0000);
        chk("dark_leds", {Led_A_Grn, Led_A_Red, Led_B_Grn, Led_B_Red}, 4'b0000);
        Wink = 1'b0;
        repeat (2 * FRAME) step();
        for (int k = 0; k < 4; k++) begin
            Wink = ~Wink;
            repeat ($urandom_range(20, 5 * FRAME)) begin
                random_poke();
                step();
            end
        end
        Wink = 1'b0;
        step();

        // Asynchronous reset in the middle of a slot.
        while ((m_n % SD) != 4) step();
        A_Light = 1'b1;
        #2 Rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        chk("rst_async_seg", Seg, 7'h00);
        repeat (2) step();
        Rst_n = 1'b1;
        #1 check_outputs();
        step();
        chk("led_a_grn_after_rst", Led_A_Grn, 1'b1);
        set_digits(4'd4, 4'd8, 4'd0, 4'd6);
        repeat (2 * FRAME) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
